// File: rtl/bus_pkg.sv
// Shared definitions for the single-master bus front end: FSM states,
// default bus widths and r_w direction encoding.
package bus_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating REQ-phase cycle counter; expired is high during the last
// cycle the master may wait for ready before it must abort.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;

  // Clear wins over enable; the count holds at TIMEOUT instead of wrapping.
  always_comb begin
    cnt_nx = cnt_q;
    if (clear) begin
      cnt_nx = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_nx = cnt_q + CNT_W'(1);
    end
  end

  // expired is flagged one cycle early so the abort lands on the TIMEOUT-th edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_nx;
      expired <= (cnt_nx >= CNT_LAST);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// CPU load/store to shared-bus bridge: arbitrates for ownership, runs one
// transfer with timeout, and releases all bus lines when not owning the bus.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              arb_req,
  input  logic              arb_grant,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_r_w,
  output logic              bus_request,
  inout  wire  [DATA_W-1:0] bus_data,
  input  logic              bus_ready
);

  state_t state_q;
  state_t state_nx;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              ready_hit_c;
  logic              expired;
  logic              ctr_clear_c;
  logic              ctr_en_c;

  // Only a solid logic 1 on the pulled-down ready line counts as ready.
  assign ready_hit_c = (bus_ready == 1'b1);
  assign ctr_clear_c = (state_q == ST_ARB) && arb_grant;
  assign ctr_en_c    = (state_q == ST_REQ);

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .clr_n   (clr_n),
    .clear   (ctr_clear_c),
    .enable  (ctr_en_c),
    .expired (expired)
  );

  // Next-state logic; a grant drop during REQ is deliberately ignored.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (cpu_req)                   state_nx = ST_ARB;
      ST_ARB:  if (arb_grant)                 state_nx = ST_REQ;
      ST_REQ:  if (ready_hit_c || expired)    state_nx = ST_IDLE;
      default:                                state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Registered CPU/arbiter outputs and bus drive enable, all derived from the next state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      we_q      <= BUS_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
      arb_req   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      cpu_busy <= (state_nx != ST_IDLE);
      arb_req  <= (state_nx != ST_IDLE);
      drive_q  <= (state_nx == ST_REQ);
      if ((state_q == ST_IDLE) && cpu_req) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (state_q == ST_REQ) begin
        if (ready_hit_c) begin
          cpu_done <= 1'b1;
          if (we_q == BUS_READ) begin
            cpu_rdata <= bus_data;
          end
        end else if (expired) begin
          cpu_done <= 1'b1;
          cpu_err  <= 1'b1;
        end
      end
    end
  end

  // Shared lines float whenever this master is not in REQ, including during reset.
  assign bus_request = drive_q ? 1'b1 : 1'bz;
  assign bus_address = drive_q ? addr_q : {ADDR_W{1'bz}};
  assign bus_r_w     = drive_q ? we_q : 1'bz;
  assign bus_data    = (drive_q && (we_q == BUS_WRITE)) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: arbiter/slave bus models, a
// transaction-level reference model and a per-cycle monitor.
module tb_bus_master_port;

  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    int          accept;
    int          req_start;
    int          req_end;
    int          done_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_busy;
  logic        arb_req;
  logic        arb_grant;
  logic        bus_ready;
  tri0  [31:0] bus_address;
  tri0         bus_r_w;
  tri0         bus_request;
  tri0  [31:0] bus_data;

  logic        slv_drive;
  logic [31:0] slv_data;
  assign bus_data = slv_drive ? slv_data : 32'bz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int idle_at = 0;
  int last_req_start = 0;
  int arb_delay = 0;
  int arb_cnt = 0;
  int slv_wait = 0;
  int slv_cnt = 0;

  exp_t        exp_q[$];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ref_rdata = 32'h0;

  bus_master_port #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_done    (cpu_done),
    .cpu_err     (cpu_err),
    .cpu_busy    (cpu_busy),
    .arb_req     (arb_req),
    .arb_grant   (arb_grant),
    .bus_address (bus_address),
    .bus_r_w     (bus_r_w),
    .bus_request (bus_request),
    .bus_data    (bus_data),
    .bus_ready   (bus_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : (a ^ 32'hA5A5_A5A5);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_A5A5);
  endfunction

  // Arbiter grants after arb_delay cycles of request; slave answers after slv_wait REQ cycles.
  always @(negedge clk) begin
    if (arb_req === 1'b1) begin
      arb_grant = (arb_cnt >= arb_delay);
      arb_cnt++;
    end else begin
      arb_grant = 1'b0;
      arb_cnt = 0;
    end
    if ((bus_request === 1'b1) && (bus_address[31:16] != 16'hFFFF)) begin
      if (bus_r_w === 1'b0) begin
        slv_data  = slv_rd(bus_address);
        slv_drive = 1'b1;
      end
      if (slv_cnt >= slv_wait) begin
        bus_ready = 1'b1;
        if (bus_r_w === 1'b1) slv_mem[bus_address] = bus_data;
      end
      slv_cnt++;
    end else begin
      slv_cnt   = 0;
      bus_ready = 1'b0;
      slv_drive = 1'b0;
    end
  end

  // Issue one CPU transfer once the model says the port is idle; push its expected outcome.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int g, input int w, input bit hold);
    exp_t e;
    bit   ok;
    int   r;
    while (cyc < idle_at) @(negedge clk);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    arb_delay = g;
    slv_wait  = w;
    ok = (addr[31:16] != 16'hFFFF) && (w + 1 <= int'(TIMEOUT));
    r  = ok ? w + 1 : int'(TIMEOUT);
    e.accept    = cyc + 1;
    e.req_start = e.accept + g + 1;
    e.req_end   = e.req_start + r - 1;
    e.done_cyc  = e.req_end + 1;
    e.we        = we;
    e.addr      = addr;
    e.wdata     = wdata;
    e.err       = !ok;
    if (ok && we)  ref_mem[addr] = wdata;
    if (ok && !we) ref_rdata = ref_rd(addr);
    e.rdata = ref_rdata;
    idle_at = e.done_cyc;
    last_req_start = e.req_start;
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) cpu_req = 1'b0;
  endtask

  // Monitor: checks bus ownership, handshake outputs and completions every cycle.
  initial begin
    exp_t h;
    bit   have;
    bit   in_req;
    bit   busy_e;
    bit   done_e;
    forever begin
      @(negedge clk);
      #1;
      if (clr_n !== 1'b1) continue;
      have = exp_q.size() > 0;
      if (have) h = exp_q[0];
      in_req = have && (cyc >= h.req_start) && (cyc <= h.req_end);
      busy_e = have && (cyc >= h.accept) && (cyc < h.done_cyc);
      done_e = have && (cyc == h.done_cyc);
      chk("bus_request", 32'(bus_request), 32'(in_req));
      chk("cpu_busy", 32'(cpu_busy), 32'(busy_e));
      chk("arb_req", 32'(arb_req), 32'(busy_e));
      chk("cpu_done", 32'(cpu_done), 32'(done_e));
      if (in_req) begin
        chk("bus_address", bus_address, h.addr);
        chk("bus_r_w", 32'(bus_r_w), 32'(h.we));
        if (h.we) chk("bus_wdata", bus_data, h.wdata);
      end else begin
        chk("released_address", bus_address, 32'h0);
        chk("released_r_w", 32'(bus_r_w), 32'h0);
        chk("released_data", bus_data, 32'h0);
      end
      if (done_e) begin
        chk("cpu_err", 32'(cpu_err), 32'(h.err));
        chk("cpu_rdata", cpu_rdata, h.rdata);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    int          g_r;
    int          w_r;
    bit          hold_r;

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    arb_grant = 1'b0; bus_ready = 1'b0; slv_drive = 1'b0; slv_data = '0;
    clr_n = 1'b1;
    #1 clr_n = 1'b0;
    #1;
    chk("reset_done", 32'(cpu_done), 32'h0);
    chk("reset_err", 32'(cpu_err), 32'h0);
    chk("reset_busy", 32'(cpu_busy), 32'h0);
    chk("reset_arb_req", 32'(arb_req), 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_request", 32'(bus_request), 32'h0);
    chk("reset_address", bus_address, 32'h0);

    slv_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    idle_at = cyc;

    // Plain read, write/readback, arbitration delay
    issue(1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
    issue(1'b1, 32'h20, 32'h12345678, 0, 0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 0, 0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 5, 0, 1'b0);
    // Timeout, ready on the timeout edge, slave one cycle too slow
    issue(1'b0, 32'hFFFF0000, 32'h0, 0, 0, 1'b0);
    issue(1'b1, 32'h24, 32'hCAFE0024, 0, 14, 1'b0);
    issue(1'b0, 32'h24, 32'h0, 1, 15, 1'b0);
    issue(1'b1, 32'h28, 32'h55AA55AA, 0, 15, 1'b0);
    issue(1'b0, 32'h24, 32'h0, 0, 2, 1'b0);
    issue(1'b0, 32'h28, 32'h0, 0, 0, 1'b0);
    // Back-to-back with cpu_req held
    issue(1'b0, 32'h1, 32'h0, 0, 0, 1'b1);
    issue(1'b0, 32'h2, 32'h0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of REQ
    issue(1'b0, 32'hFFFF0000, 32'h0, 0, 0, 1'b0);
    while (cyc < last_req_start + 3) @(negedge clk);
    #2 clr_n = 1'b0;
    exp_q.delete();
    ref_rdata = 32'h0;
    #1;
    chk("midreq_reset_request", 32'(bus_request), 32'h0);
    chk("midreq_reset_address", bus_address, 32'h0);
    chk("midreq_reset_busy", 32'(cpu_busy), 32'h0);
    chk("midreq_reset_arb_req", 32'(arb_req), 32'h0);
    chk("midreq_reset_done", 32'(cpu_done), 32'h0);
    chk("midreq_reset_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    idle_at = cyc;

    for (int i = 0; i < 40; i++) begin
      we_r    = 1'($urandom_range(0, 1));
      wdata_r = $urandom;
      if ($urandom_range(0, 9) == 0) addr_r = 32'hFFFF0000 | 32'($urandom_range(0, 255) * 4);
      else                           addr_r = 32'h100 + 32'($urandom_range(0, 15) * 4);
      g_r = int'($urandom_range(0, 3));
      w_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 3));
      hold_r = (i != 39) && ($urandom_range(0, 3) == 0);
      issue(we_r, addr_r, wdata_r, g_r, w_r, hold_r);
    end

    while (cyc < idle_at + 2) @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
